// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: one 32-bit load/store as two 16-bit SRAM halfword
// phases with programmable wait states; freezes the pipeline until done.
module mem_access_ctrl #(
   parameter int ADDRESS_LEN   = 32,
   parameter int REGISTER_LEN  = 32,
   parameter int SRAM_ADDR_LEN = 18,
   parameter int BASE_ADDR     = 1024,
   parameter int WAIT_CYCLES   = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     mem_r_en,
   input  logic                     mem_w_en,
   input  logic [ADDRESS_LEN-1:0]   address,
   input  logic [REGISTER_LEN-1:0]  wr_data,
   output logic [REGISTER_LEN-1:0]  rd_data,
   output logic                     ready,
   output logic                     freeze,
   output logic [SRAM_ADDR_LEN-1:0] sram_addr,
   output logic [15:0]              sram_dq_out,
   output logic                     sram_dq_oe,
   input  logic [15:0]              sram_dq_in,
   output logic                     sram_we_n
);

   localparam int WAIT_W   = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam int WORD_LEN = SRAM_ADDR_LEN - 1;

   typedef enum logic [2:0] {
      IDLE,
      RD_LO,
      RD_HI,
      WR_LO,
      WR_HI,
      DONE
   } state_t;

   state_t                   state_q, state_d;
   logic [WAIT_W-1:0]        wait_q, wait_d;
   logic [WORD_LEN-1:0]      word_q, word_d;
   logic [15:0]              wdata_hi_q, wdata_hi_d;
   logic [15:0]              buf_lo_q, buf_lo_d;
   logic [REGISTER_LEN-1:0]  rd_data_q, rd_data_d;
   logic                     ready_q, ready_d;
   logic [SRAM_ADDR_LEN-1:0] sram_addr_q, sram_addr_d;
   logic [15:0]              sram_dq_out_q, sram_dq_out_d;
   logic                     sram_dq_oe_q, sram_dq_oe_d;
   logic                     sram_we_n_q, sram_we_n_d;

   logic [ADDRESS_LEN-1:0]   off;
   logic [WORD_LEN-1:0]      req_word;
   logic                     phase_end;
   logic                     unused_addr_bits;

   // Byte offset from the SRAM window; byte-in-word bits and bits above the
   // SRAM range are dropped, so addresses wrap around the SRAM.
   always_comb begin
      off              = address - ADDRESS_LEN'(BASE_ADDR);
      req_word         = off[SRAM_ADDR_LEN:2];
      unused_addr_bits = ^{off[ADDRESS_LEN-1:SRAM_ADDR_LEN+1], off[1:0]};
      phase_end        = (wait_q == WAIT_W'(WAIT_CYCLES));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         wait_q        <= '0;
         word_q        <= '0;
         wdata_hi_q    <= '0;
         buf_lo_q      <= '0;
         rd_data_q     <= '0;
         ready_q       <= 1'b0;
         sram_addr_q   <= '0;
         sram_dq_out_q <= '0;
         sram_dq_oe_q  <= 1'b0;
         sram_we_n_q   <= 1'b1;
      end else begin
         state_q       <= state_d;
         wait_q        <= wait_d;
         word_q        <= word_d;
         wdata_hi_q    <= wdata_hi_d;
         buf_lo_q      <= buf_lo_d;
         rd_data_q     <= rd_data_d;
         ready_q       <= ready_d;
         sram_addr_q   <= sram_addr_d;
         sram_dq_out_q <= sram_dq_out_d;
         sram_dq_oe_q  <= sram_dq_oe_d;
         sram_we_n_q   <= sram_we_n_d;
      end
   end

   // SRAM pins are registered, so each phase's values are loaded on the edge
   // that enters the phase rather than decoded from the current state.
   always_comb begin
      state_d       = state_q;
      wait_d        = wait_q;
      word_d        = word_q;
      wdata_hi_d    = wdata_hi_q;
      buf_lo_d      = buf_lo_q;
      rd_data_d     = rd_data_q;
      ready_d       = 1'b0;
      sram_addr_d   = sram_addr_q;
      sram_dq_out_d = sram_dq_out_q;
      sram_dq_oe_d  = sram_dq_oe_q;
      sram_we_n_d   = sram_we_n_q;

      unique case (state_q)
         IDLE: begin
            wait_d       = '0;
            sram_we_n_d  = 1'b1;
            sram_dq_oe_d = 1'b0;
            if (mem_r_en) begin
               state_d     = RD_LO;
               word_d      = req_word;
               sram_addr_d = {req_word, 1'b0};
            end else if (mem_w_en) begin
               state_d       = WR_LO;
               word_d        = req_word;
               wdata_hi_d    = wr_data[31:16];
               sram_addr_d   = {req_word, 1'b0};
               sram_dq_out_d = wr_data[15:0];
               sram_we_n_d   = 1'b0;
               sram_dq_oe_d  = 1'b1;
            end
         end
         RD_LO: begin
            if (phase_end) begin
               state_d     = RD_HI;
               wait_d      = '0;
               buf_lo_d    = sram_dq_in;
               sram_addr_d = {word_q, 1'b1};
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         RD_HI: begin
            if (phase_end) begin
               state_d   = DONE;
               wait_d    = '0;
               rd_data_d = REGISTER_LEN'({sram_dq_in, buf_lo_q});
               ready_d   = 1'b1;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         WR_LO: begin
            if (phase_end) begin
               state_d       = WR_HI;
               wait_d        = '0;
               sram_addr_d   = {word_q, 1'b1};
               sram_dq_out_d = wdata_hi_q;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         WR_HI: begin
            if (phase_end) begin
               state_d      = DONE;
               wait_d       = '0;
               sram_we_n_d  = 1'b1;
               sram_dq_oe_d = 1'b0;
               ready_d      = 1'b1;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      rd_data     = rd_data_q;
      ready       = ready_q;
      freeze      = (mem_r_en | mem_w_en) & ~ready_q;
      sram_addr   = sram_addr_q;
      sram_dq_out = sram_dq_out_q;
      sram_dq_oe  = sram_dq_oe_q;
      sram_we_n   = sram_we_n_q;
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a behavioural 16-bit SRAM model.
module tb_mem_access_ctrl;

   logic        clk;
   logic        rst;
   logic        mem_r_en;
   logic        mem_w_en;
   logic [31:0] address;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic        ready;
   logic        freeze;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out;
   logic        sram_dq_oe;
   logic [15:0] sram_dq_in;
   logic        sram_we_n;

   mem_access_ctrl #(
      .ADDRESS_LEN  (32),
      .REGISTER_LEN (32),
      .SRAM_ADDR_LEN(18),
      .BASE_ADDR    (1024),
      .WAIT_CYCLES  (1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .mem_r_en   (mem_r_en),
      .mem_w_en   (mem_w_en),
      .address    (address),
      .wr_data    (wr_data),
      .rd_data    (rd_data),
      .ready      (ready),
      .freeze     (freeze),
      .sram_addr  (sram_addr),
      .sram_dq_out(sram_dq_out),
      .sram_dq_oe (sram_dq_oe),
      .sram_dq_in (sram_dq_in),
      .sram_we_n  (sram_we_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // SRAM model: filled with 0xA000+index during reset, written on each edge
   // while the write strobe is low.
   logic [15:0] mem [64];
   logic        mem_init_done = 1'b0;
   always @(posedge clk) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 64; i++) mem[i] <= 16'hA000 + 16'(i);
         mem_init_done <= 1'b1;
      end else if (!sram_we_n) begin
         mem[sram_addr[5:0]] <= sram_dq_out;
      end
   end
   always_comb sram_dq_in = mem[sram_addr[5:0]];

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] rd;
      int          start;
   } exp_t;
   exp_t sbq[$];

   // Monitor: every ready pulse must match the oldest outstanding access.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (ready) begin
            if (sbq.size() == 0) begin
               check("spurious_ready", {31'b0, ready}, 32'd0);
            end else begin
               e = sbq.pop_front();
               check("sb_rd_data", rd_data, e.rd);
               check("sb_latency", 32'(cyc - e.start), 32'd5);
            end
         end
      end
   end

   int          frz_cnt;
   int          wen_cnt;
   logic [17:0] addr_lo;
   logic [17:0] addr_hi;
   logic        got_ready;

   // Issues one access at the cycle after the next edge and returns in the
   // ready cycle, leaving the request asserted through DONE.
   task automatic access(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp_rd);
      exp_t e;
      @(posedge clk);
      #1;
      mem_r_en = r;
      mem_w_en = w;
      address  = a;
      wr_data  = d;
      e.rd     = exp_rd;
      e.start  = cyc;
      sbq.push_back(e);
      frz_cnt   = 0;
      wen_cnt   = 0;
      addr_lo   = '0;
      addr_hi   = '0;
      got_ready = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (freeze) frz_cnt++;
         if (!sram_we_n) wen_cnt++;
         if (i == 1) addr_lo = sram_addr;
         if (i == 3) addr_hi = sram_addr;
         if (ready) begin
            got_ready = 1'b1;
            break;
         end
      end
   endtask

   task automatic check_access(input string nm, input int exp_wen,
                               input logic [17:0] exp_lo, input logic [17:0] exp_hi);
      check({nm, "_ready_seen"}, {31'b0, got_ready}, 32'd1);
      check({nm, "_freeze_cycles"}, 32'(frz_cnt), 32'd5);
      check({nm, "_we_n_low_cycles"}, 32'(wen_cnt), 32'(exp_wen));
      check({nm, "_addr_lo"}, {14'b0, addr_lo}, {14'b0, exp_lo});
      check({nm, "_addr_hi"}, {14'b0, addr_hi}, {14'b0, exp_hi});
   endtask

   task automatic idle(input int n);
      @(posedge clk);
      #1;
      mem_r_en = 1'b0;
      mem_w_en = 1'b0;
      repeat (n - 1) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int rdy_seen;

   initial begin
      rst      = 1'b1;
      mem_r_en = 1'b0;
      mem_w_en = 1'b0;
      address  = '0;
      wr_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_rd_data", rd_data, 32'd0);
      check("rst_ready", {31'b0, ready}, 32'd0);
      check("rst_freeze", {31'b0, freeze}, 32'd0);
      check("rst_we_n", {31'b0, sram_we_n}, 32'd1);
      check("rst_oe", {31'b0, sram_dq_oe}, 32'd0);
      check("rst_sram_addr", {14'b0, sram_addr}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'd0);
      check_access("store1024", 4, 18'd0, 18'd1);
      check("store_mem0", {16'b0, mem[0]}, 32'h0000BEEF);
      check("store_mem1", {16'b0, mem[1]}, 32'h0000DEAD);
      idle(2);

      access(1'b1, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF);
      check_access("load1024", 0, 18'd0, 18'd1);
      idle(3);
      check("load_hold", rd_data, 32'hDEADBEEF);
      check("idle_we_n", {31'b0, sram_we_n}, 32'd1);
      check("idle_oe", {31'b0, sram_dq_oe}, 32'd0);
      check("idle_freeze", {31'b0, freeze}, 32'd0);

      access(1'b1, 1'b0, 32'd1028, 32'h0, 32'hA003A002);
      check_access("load1028", 0, 18'd2, 18'd3);
      idle(2);

      access(1'b0, 1'b1, 32'd1032, 32'h12345678, 32'hA003A002);
      check_access("b2b_store", 4, 18'd4, 18'd5);
      access(1'b1, 1'b0, 32'd1032, 32'h0, 32'h12345678);
      check_access("b2b_load", 0, 18'd4, 18'd5);

      access(1'b1, 1'b1, 32'd1032, 32'hFFFFFFFF, 32'h12345678);
      check_access("conflict", 0, 18'd4, 18'd5);
      check("conflict_mem4", {16'b0, mem[4]}, 32'h00005678);
      idle(2);

      access(1'b1, 1'b0, 32'd1024 + 32'd524288, 32'h0, 32'hDEADBEEF);
      check_access("wrap", 0, 18'd0, 18'd1);
      idle(2);

      // Mid-cycle reset while idle with non-reset output values.
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("midrst_rd_data", rd_data, 32'd0);
      check("midrst_sram_addr", {14'b0, sram_addr}, 32'd0);
      check("midrst_dq_out", {16'b0, sram_dq_out}, 32'd0);
      check("midrst_we_n", {31'b0, sram_we_n}, 32'd1);
      check("midrst_ready", {31'b0, ready}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Abort a store while it is in its high-halfword phase.
      @(posedge clk);
      #1;
      mem_w_en = 1'b1;
      address  = 32'd1040;
      wr_data  = 32'hCAFEF00D;
      repeat (3) @(posedge clk);
      #2;
      check("abort_pre_we_n", {31'b0, sram_we_n}, 32'd0);
      check("abort_pre_addr", {14'b0, sram_addr}, 32'd9);
      rst = 1'b1;
      #1;
      check("abort_we_n", {31'b0, sram_we_n}, 32'd1);
      check("abort_oe", {31'b0, sram_dq_oe}, 32'd0);
      check("abort_freeze", {31'b0, freeze}, 32'd1);
      @(posedge clk);
      #1;
      mem_w_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      rdy_seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (ready) rdy_seen++;
      end
      check("abort_no_ready", 32'(rdy_seen), 32'd0);
      check("abort_rd_data", rd_data, 32'd0);
      check("abort_mem8", {16'b0, mem[8]}, 32'h0000F00D);
      check("abort_mem9", {16'b0, mem[9]}, 32'h0000A009);

      access(1'b1, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF);
      check_access("post_abort_load", 0, 18'd0, 18'd1);
      idle(3);

      check("sb_drain", 32'(sbq.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
